// File: rtl/sign_expand_pkg.sv
// Shared definitions for the multi-channel pulse expander.
// Holds the state encoding and the default counter width.
package sign_expand_pkg;

    localparam int DEFAULT_CNT_W = 7;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'b00;
    localparam state_t HOLD = 2'b01;
    localparam state_t LOW  = 2'b10;

endpackage

// File: rtl/sign_expand_chan.sv
// One expander channel: IDLE -> HOLD (output high) -> LOW (dead time) -> IDLE.
// Lengths are latched into shadow registers when a pulse is accepted.
module sign_expand_chan
    import sign_expand_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             trig,
    input  logic [CNT_W-1:0] hold_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic             retrig,
    input  logic             clear_missed,
    output logic             signal_out,
    output logic             busy,
    output logic             missed,
    output logic [1:0]       state
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    logic [CNT_W-1:0] low_q;
    logic [CNT_W-1:0] low_d;
    logic [CNT_W-1:0] hold_eff;
    logic             drop;
    logic             out_d;
    logic             busy_d;
    logic             missed_d;

    // A zero hold length still yields a one-cycle pulse.
    assign hold_eff = (hold_len == '0) ? CNT_W'(1) : hold_len;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        low_d   = low_q;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(1);
                    hold_d  = hold_eff;
                    low_d   = low_len;
                end
            end
            HOLD: begin
                if (trig && retrig) begin
                    cnt_d  = CNT_W'(1);
                    hold_d = hold_eff;
                end else begin
                    drop = trig;
                    if (cnt_q >= hold_q) begin
                        if (low_q != '0) begin
                            state_d = LOW;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            LOW: begin
                drop = trig;
                if (cnt_q >= low_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        out_d    = (state_d == HOLD);
        busy_d   = (state_d != IDLE);
        // A drop on the same cycle as a clear still leaves the flag set.
        missed_d = drop | (missed & ~clear_missed);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            low_q      <= '0;
            signal_out <= 1'b0;
            busy       <= 1'b0;
            missed     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            low_q      <= low_d;
            signal_out <= out_d;
            busy       <= busy_d;
            missed     <= missed_d;
        end
    end

    assign state = state_q;

    hold_cnt_range: assert property (@(posedge clock) disable iff (!reset)
        (state_q == HOLD) |-> (cnt_q >= CNT_W'(1) && cnt_q <= hold_q));

    low_cnt_range: assert property (@(posedge clock) disable iff (!reset)
        (state_q == LOW) |-> (cnt_q >= CNT_W'(1) && cnt_q <= low_q));

    out_implies_busy: assert property (@(posedge clock) disable iff (!reset)
        signal_out |-> busy);

endmodule

// File: rtl/sign_expand_multi.sv
// Multi-channel pulse expander: shared edge detector feeding CH independent channels.
// Channels share only the length/mode configuration inputs.
module sign_expand_multi
    import sign_expand_pkg::*;
#(
    parameter int CH    = 4,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CH-1:0]     signal_in,
    input  logic [CNT_W-1:0]  hold_len,
    input  logic [CNT_W-1:0]  low_len,
    input  logic              edge_mode,
    input  logic              retrig,
    input  logic              clear_missed,
    output logic [CH-1:0]     signal_out,
    output logic [CH-1:0]     busy,
    output logic [CH-1:0]     missed,
    output logic [2*CH-1:0]   chan_state
);

    logic [CH-1:0] prev_in;
    logic [CH-1:0] trig;

    // History clears on reset so an input already high at release counts as an edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_in <= '0;
        end else begin
            prev_in <= signal_in;
        end
    end

    assign trig = edge_mode ? (signal_in & ~prev_in) : signal_in;

    for (genvar i = 0; i < CH; i++) begin : g_chan
        sign_expand_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clock        (clock),
            .reset        (reset),
            .trig         (trig[i]),
            .hold_len     (hold_len),
            .low_len      (low_len),
            .retrig       (retrig),
            .clear_missed (clear_missed),
            .signal_out   (signal_out[i]),
            .busy         (busy[i]),
            .missed       (missed[i]),
            .state        (chan_state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_sign_expand_multi.sv
// Directed bench for sign_expand_multi: a driver pushes hand-derived expected
// outputs per clock into a queue; a monitor pops and compares after every edge.
module tb_sign_expand_multi;

    localparam int CH    = 4;
    localparam int CNT_W = 7;
    localparam int W     = 3 * CH;

    logic             clock = 1'b0;
    logic             reset;
    logic [CH-1:0]    signal_in;
    logic [CNT_W-1:0] hold_len;
    logic [CNT_W-1:0] low_len;
    logic             edge_mode;
    logic             retrig;
    logic             clear_missed;
    logic [CH-1:0]    signal_out;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    missed;
    logic [2*CH-1:0]  chan_state;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    string        test_name;
    int           checks = 0;
    int           passed = 0;

    always #5 clock = ~clock;

    sign_expand_multi #(
        .CH    (CH),
        .CNT_W (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .signal_in    (signal_in),
        .hold_len     (hold_len),
        .low_len      (low_len),
        .edge_mode    (edge_mode),
        .retrig       (retrig),
        .clear_missed (clear_missed),
        .signal_out   (signal_out),
        .busy         (busy),
        .missed       (missed),
        .chan_state   (chan_state)
    );

    function automatic logic r(input int t, input int a, input int b);
        return (t >= a) && (t <= b);
    endfunction

    // Drive inputs for the next rising edge and queue what must be visible after it.
    task automatic step(input logic rst_n, input logic [CH-1:0] sin, input logic clr,
                        input logic [CH-1:0] e_out, input logic [CH-1:0] e_busy,
                        input logic [CH-1:0] e_missed, input int t);
        @(negedge clock);
        reset        = rst_n;
        signal_in    = sin;
        clear_missed = clr;
        exp_q.push_back({e_out, e_busy, e_missed});
        tag_q.push_back($sformatf("%s t=%0d", test_name, t));
    endtask

    task automatic do_reset();
        for (int t = -2; t < 0; t++) begin
            step(1'b0, '0, 1'b0, '0, '0, '0, t);
        end
    endtask

    // Monitor
    initial begin
        logic [W-1:0] exp;
        string        tag;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                checks++;
                if ({signal_out, busy, missed} === exp) begin
                    passed++;
                end else begin
                    $display("FAIL %s: out/busy/missed got %b/%b/%b want %b/%b/%b",
                             tag, signal_out, busy, missed,
                             exp[W-1 -: CH], exp[2*CH-1 -: CH], exp[CH-1:0]);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        signal_in    = '0;
        clear_missed = 1'b0;
        hold_len     = '0;
        low_len      = '0;
        edge_mode    = 1'b0;
        retrig       = 1'b0;

        // Edge trigger, drop during LOW, re-accept, clear of missed.
        test_name = "edge_basic";
        edge_mode = 1'b1; retrig = 1'b0; hold_len = 7'd5; low_len = 7'd3;
        do_reset();
        for (int t = 0; t < 30; t++) begin
            step(1'b1, {3'b0, r(t, 10, 12) || r(t, 16, 17) || r(t, 19, 20)}, t == 25,
                 {3'b0, r(t, 10, 14) || r(t, 19, 23)},
                 {3'b0, r(t, 10, 17) || r(t, 19, 26)},
                 {3'b0, r(t, 16, 24)}, t);
        end

        // Retrigger extends the pulse without flagging a drop.
        test_name = "retrig";
        edge_mode = 1'b1; retrig = 1'b1; hold_len = 7'd4; low_len = 7'd3;
        do_reset();
        for (int t = 0; t < 25; t++) begin
            step(1'b1, {3'b0, (t == 10) || (t == 12)}, 1'b0,
                 {3'b0, r(t, 10, 15)},
                 {3'b0, r(t, 10, 18)},
                 4'b0, t);
        end

        // Level mode held high, no retrigger: period hold+low+1 on channel 1.
        test_name = "level_periodic";
        edge_mode = 1'b0; retrig = 1'b0; hold_len = 7'd2; low_len = 7'd1;
        do_reset();
        for (int t = 0; t < 27; t++) begin
            step(1'b1, {2'b0, r(t, 5, 20), 1'b0}, 1'b0,
                 {2'b0, r(t, 5, 20) && ((t - 5) % 4 < 2), 1'b0},
                 {2'b0, r(t, 5, 20) && ((t - 5) % 4 != 3), 1'b0},
                 {2'b0, t >= 6, 1'b0}, t);
        end

        // Level mode held high with retrigger: output stays high on channel 2.
        test_name = "level_retrig";
        edge_mode = 1'b0; retrig = 1'b1; hold_len = 7'd2; low_len = 7'd1;
        do_reset();
        for (int t = 0; t < 22; t++) begin
            step(1'b1, {1'b0, r(t, 3, 15), 2'b0}, 1'b0,
                 {1'b0, r(t, 3, 16), 2'b0},
                 {1'b0, r(t, 3, 17), 2'b0},
                 4'b0, t);
        end

        // Zero lengths: one-cycle pulses, re-accepted every second edge on channel 3.
        test_name = "zero_len";
        edge_mode = 1'b0; retrig = 1'b0; hold_len = 7'd0; low_len = 7'd0;
        do_reset();
        for (int t = 0; t < 15; t++) begin
            step(1'b1, {r(t, 4, 9), 3'b0}, 1'b0,
                 {(t == 4) || (t == 6) || (t == 8), 3'b0},
                 {(t == 4) || (t == 6) || (t == 8), 3'b0},
                 {t >= 5, 3'b0}, t);
        end

        // Maximum hold length; lengths changed mid-pulse must not matter.
        test_name = "max_len";
        edge_mode = 1'b1; retrig = 1'b0; hold_len = 7'd127; low_len = 7'd0;
        do_reset();
        for (int t = 0; t < 133; t++) begin
            if (t == 50) begin
                hold_len = 7'd3;
                low_len  = 7'd5;
            end
            step(1'b1, {3'b0, t == 2}, 1'b0,
                 {3'b0, r(t, 2, 128)},
                 {3'b0, r(t, 2, 128)},
                 4'b0, t);
        end

        // Reset during HOLD on all channels; fresh pulses after release.
        test_name = "mid_reset";
        edge_mode = 1'b1; retrig = 1'b0; hold_len = 7'd10; low_len = 7'd2;
        do_reset();
        for (int t = 0; t < 27; t++) begin
            step(t != 7,
                 {{3{r(t, 3, 40)}}, (t == 3) || (t == 5) || (t == 12)}, 1'b0,
                 {{3{r(t, 3, 6) || r(t, 8, 17)}}, r(t, 3, 6) || r(t, 12, 21)},
                 {{3{r(t, 3, 6) || r(t, 8, 19)}}, r(t, 3, 6) || r(t, 12, 23)},
                 {3'b0, r(t, 5, 6)}, t);
        end

        repeat (3) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
